// File: rtl/wheel_state_buffer.sv
// -----------------------------------------------------------------------------
// wheel_state_buffer
//
// Double-buffered state store for the soft-body wheel. Per-node position and
// velocity results stream in from the updater and are collected into staging
// registers. On the updater's done pulse the staged frame is committed to the
// live state in one step, but only if both streams delivered exactly
// NUM_NODES samples and neither overflowed. A separate snapshot copy of the
// live positions is latched on each frame pulse. Render reads this copy, so it
// never sees a half-updated wheel.
//
// Ports
//   clk_in                  system clock
//   rst_in                  synchronous active-high reset, dominates all inputs
//   init_x_in / init_y_in   rest shape, loaded into live and snapshot on reset
//   node_x_in / node_y_in   streamed node position, qualified by node_valid_in
//   vel_x_in / vel_y_in     streamed node velocity, qualified by vel_valid_in
//   commit_in               updater done pulse: try to apply the staged frame
//   frame_in                new-frame pulse (already in the clk_in domain)
//   nodes_x_out/nodes_y_out live positions (fed back to the updater)
//   vels_x_out / vels_y_out live velocities
//   snap_x_out / snap_y_out render snapshot of the live positions
//   node_count_out          positions staged in the current update
//   vel_count_out           velocities staged in the current update
//   commit_ok_out           one-cycle pulse: the commit was applied
//   commit_err_out          one-cycle pulse: the commit was rejected
// -----------------------------------------------------------------------------
module wheel_state_buffer #(
    parameter  int NUM_NODES     = 10,
    parameter  int POSITION_SIZE = 18,
    parameter  int VELOCITY_SIZE = 8,
    localparam int CW            = $clog2(NUM_NODES + 1)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic signed [POSITION_SIZE-1:0] init_x_in   [NUM_NODES],
    input  logic signed [POSITION_SIZE-1:0] init_y_in   [NUM_NODES],
    input  logic signed [POSITION_SIZE-1:0] node_x_in,
    input  logic signed [POSITION_SIZE-1:0] node_y_in,
    input  logic                            node_valid_in,
    input  logic signed [VELOCITY_SIZE-1:0] vel_x_in,
    input  logic signed [VELOCITY_SIZE-1:0] vel_y_in,
    input  logic                            vel_valid_in,
    input  logic                            commit_in,
    input  logic                            frame_in,
    output logic signed [POSITION_SIZE-1:0] nodes_x_out [NUM_NODES],
    output logic signed [POSITION_SIZE-1:0] nodes_y_out [NUM_NODES],
    output logic signed [VELOCITY_SIZE-1:0] vels_x_out  [NUM_NODES],
    output logic signed [VELOCITY_SIZE-1:0] vels_y_out  [NUM_NODES],
    output logic signed [POSITION_SIZE-1:0] snap_x_out  [NUM_NODES],
    output logic signed [POSITION_SIZE-1:0] snap_y_out  [NUM_NODES],
    output logic        [CW-1:0]            node_count_out,
    output logic        [CW-1:0]            vel_count_out,
    output logic                            commit_ok_out,
    output logic                            commit_err_out
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_NODES);
    localparam logic [CW-1:0] LAST_SLOT  = CW'(NUM_NODES - 1);

    // ---------------------------------------------------------------------
    // Collector bookkeeping
    // ---------------------------------------------------------------------
    logic [CW-1:0] r_pos_count;
    logic [CW-1:0] r_vel_count;
    logic          r_pos_ovf;
    logic          r_vel_ovf;
    logic          r_commit_ok;
    logic          r_commit_err;

    // A sample is accepted only while there is a free staging slot. When the
    // array is full the sample is dropped and the stream is marked overflowed.
    logic w_pos_accept;
    logic w_vel_accept;
    logic w_pos_ovf_now;
    logic w_vel_ovf_now;

    assign w_pos_accept  = node_valid_in && (r_pos_count != FULL_COUNT);
    assign w_vel_accept  = vel_valid_in  && (r_vel_count != FULL_COUNT);
    assign w_pos_ovf_now = node_valid_in && (r_pos_count == FULL_COUNT);
    assign w_vel_ovf_now = vel_valid_in  && (r_vel_count == FULL_COUNT);

    // A stream is complete when the count, including a sample accepted in
    // this same cycle, reaches NUM_NODES. An overflow, sticky or new this
    // cycle, disqualifies the stream.
    logic w_pos_complete;
    logic w_vel_complete;
    logic w_pos_good;
    logic w_vel_good;
    logic w_commit_good;

    assign w_pos_complete = w_pos_accept ? (r_pos_count == LAST_SLOT)
                                         : (r_pos_count == FULL_COUNT);
    assign w_vel_complete = w_vel_accept ? (r_vel_count == LAST_SLOT)
                                         : (r_vel_count == FULL_COUNT);
    assign w_pos_good     = w_pos_complete && !r_pos_ovf && !w_pos_ovf_now;
    assign w_vel_good     = w_vel_complete && !r_vel_ovf && !w_vel_ovf_now;
    assign w_commit_good  = commit_in && w_pos_good && w_vel_good;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pos_count  <= '0;
            r_vel_count  <= '0;
            r_pos_ovf    <= 1'b0;
            r_vel_ovf    <= 1'b0;
            r_commit_ok  <= 1'b0;
            r_commit_err <= 1'b0;
        end else begin
            r_commit_ok  <= w_commit_good;
            r_commit_err <= commit_in && !w_commit_good;

            // A commit ends the update whatever its outcome. Samples that
            // arrive in the commit cycle belong to the update being closed,
            // so nothing carries over into the next one.
            if (commit_in) begin
                r_pos_count <= '0;
                r_vel_count <= '0;
                r_pos_ovf   <= 1'b0;
                r_vel_ovf   <= 1'b0;
            end else begin
                if (w_pos_accept)  r_pos_count <= r_pos_count + CW'(1);
                if (w_vel_accept)  r_vel_count <= r_vel_count + CW'(1);
                if (w_pos_ovf_now) r_pos_ovf   <= 1'b1;
                if (w_vel_ovf_now) r_vel_ovf   <= 1'b1;
            end
        end
    end

    assign node_count_out = r_pos_count;
    assign vel_count_out  = r_vel_count;
    assign commit_ok_out  = r_commit_ok;
    assign commit_err_out = r_commit_err;

    // ---------------------------------------------------------------------
    // Per-node storage: staging, live and snapshot registers
    // ---------------------------------------------------------------------
    logic [NUM_NODES-1:0] w_pos_wr;
    logic [NUM_NODES-1:0] w_vel_wr;

    generate
        for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_node
            logic signed [POSITION_SIZE-1:0] r_stage_x;
            logic signed [POSITION_SIZE-1:0] r_stage_y;
            logic signed [VELOCITY_SIZE-1:0] r_stage_vx;
            logic signed [VELOCITY_SIZE-1:0] r_stage_vy;
            logic signed [POSITION_SIZE-1:0] r_live_x;
            logic signed [POSITION_SIZE-1:0] r_live_y;
            logic signed [VELOCITY_SIZE-1:0] r_live_vx;
            logic signed [VELOCITY_SIZE-1:0] r_live_vy;
            logic signed [POSITION_SIZE-1:0] r_snap_x;
            logic signed [POSITION_SIZE-1:0] r_snap_y;

            // The slot written by an accepted sample is the current count.
            assign w_pos_wr[gi] = w_pos_accept && (r_pos_count == CW'(gi));
            assign w_vel_wr[gi] = w_vel_accept && (r_vel_count == CW'(gi));

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    r_stage_x  <= '0;
                    r_stage_y  <= '0;
                    r_stage_vx <= '0;
                    r_stage_vy <= '0;
                    r_live_x   <= init_x_in[gi];
                    r_live_y   <= init_y_in[gi];
                    r_live_vx  <= '0;
                    r_live_vy  <= '0;
                    r_snap_x   <= init_x_in[gi];
                    r_snap_y   <= init_y_in[gi];
                end else begin
                    if (w_pos_wr[gi]) begin
                        r_stage_x <= node_x_in;
                        r_stage_y <= node_y_in;
                    end
                    if (w_vel_wr[gi]) begin
                        r_stage_vx <= vel_x_in;
                        r_stage_vy <= vel_y_in;
                    end

                    // A sample landing in this slot during the commit cycle
                    // bypasses staging and goes straight to live.
                    if (w_commit_good) begin
                        r_live_x  <= w_pos_wr[gi] ? node_x_in : r_stage_x;
                        r_live_y  <= w_pos_wr[gi] ? node_y_in : r_stage_y;
                        r_live_vx <= w_vel_wr[gi] ? vel_x_in  : r_stage_vx;
                        r_live_vy <= w_vel_wr[gi] ? vel_y_in  : r_stage_vy;
                    end

                    // The snapshot copies the pre-edge live state, so a frame
                    // that coincides with a commit still shows the old frame.
                    if (frame_in) begin
                        r_snap_x <= r_live_x;
                        r_snap_y <= r_live_y;
                    end
                end
            end

            assign nodes_x_out[gi] = r_live_x;
            assign nodes_y_out[gi] = r_live_y;
            assign vels_x_out[gi]  = r_live_vx;
            assign vels_y_out[gi]  = r_live_vy;
            assign snap_x_out[gi]  = r_snap_x;
            assign snap_y_out[gi]  = r_snap_y;
        end
    endgenerate

endmodule
